adc_spi_sampler: RTL and testbench

Front-end sample source for the BPM pre-processing chain. It runs an SPI master transaction against the external 10-bit pressure ADC once per sample period and deserializes the returned frame. It then presents one signed sample per period as a single-cycle valid strobe, which drives the high-pass filter's `en` and `x_in` directly. The block owns sample-rate generation and frame timing, and flags sample periods it could not service.

---
 rtl/adc_spi_sampler.sv | 174 +++++++++++++++++
 tb/tb_adc_spi_sampler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_sampler.sv
// Periodic SPI read of an external ADC, presenting one signed sample per period as a one-cycle strobe.
// Build option: define ADC_SPI_TWOS_COMP_EN to convert offset-binary ADC words to two's complement.
module adc_spi_sampler #(
    parameter int Width      = 10,
    parameter int CLK_DIV    = 4,
    parameter int FRAME_BITS = 16,
    parameter int NULL_BITS  = 3,
    parameter int SAMPLE_DIV = 20000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    output logic                    adc_cs_n,
    output logic                    adc_sclk,
    input  logic                    adc_miso,
    output logic signed [Width-1:0] sample_out,
    output logic                    sample_valid,
    output logic                    overrun
);

    if (CLK_DIV < 2) begin : g_chk_clk_div
        $error("adc_spi_sampler: CLK_DIV must be at least 2");
    end
    if (NULL_BITS + Width > FRAME_BITS) begin : g_chk_frame
        $error("adc_spi_sampler: NULL_BITS + Width must not exceed FRAME_BITS");
    end
    if (SAMPLE_DIV <= 34 * CLK_DIV + 2) begin : g_chk_sample_div
        $error("adc_spi_sampler: SAMPLE_DIV must exceed 34*CLK_DIV + 2");
    end

    localparam int CNT_W = $clog2(SAMPLE_DIV);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(FRAME_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] DATA_FIRST = BIT_W'(NULL_BITS);
    localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(NULL_BITS + Width - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_DONE
    } state_t;

    function automatic logic signed [Width-1:0] to_sample(input logic [Width-1:0] raw);
`ifdef ADC_SPI_TWOS_COMP_EN
        return $signed({~raw[Width-1], raw[Width-2:0]});
`else
        return $signed(raw);
`endif
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d  = '0;
        tick_d = 1'b0;
        if (enable) begin
            if (cnt_q == CNT_LAST) begin
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    state_t                  state_q;
    logic [DIV_W-1:0]        div_q;
    logic [BIT_W-1:0]        bit_q;
    logic [Width-1:0]        data_q;
    logic                    cs_n_q;
    logic                    sclk_q;
    logic                    valid_q;
    logic                    overrun_q;
    logic signed [Width-1:0] sample_q;

    // Frame sequencer: every output is a register written on state transitions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            data_q    <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            sample_q  <= '0;
        end else begin
            valid_q <= 1'b0;
            if (tick_q && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (tick_q) begin
                        state_q <= S_SETUP;
                        cs_n_q  <= 1'b0;
                        div_q   <= '0;
                    end
                end
                S_SETUP: begin
                    if (div_q == DIV_LAST) begin
                        state_q <= S_SHIFT;
                        sclk_q  <= 1'b1;
                        div_q   <= '0;
                        bit_q   <= '0;
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (div_q == DIV_LAST) begin
                        div_q <= '0;
                        if (sclk_q) begin
                            // End of the high phase: the ADC has not yet moved to the next bit.
                            sclk_q <= 1'b0;
                            if ((bit_q >= DATA_FIRST) && (bit_q <= DATA_LAST)) begin
                                data_q <= {data_q[Width-2:0], adc_miso};
                            end
                        end else if (bit_q == BIT_LAST) begin
                            state_q <= S_HOLD;
                        end else begin
                            bit_q  <= bit_q + BIT_W'(1);
                            sclk_q <= 1'b1;
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                S_HOLD: begin
                    if (div_q == DIV_LAST) begin
                        state_q <= S_DONE;
                        cs_n_q  <= 1'b1;
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                S_DONE: begin
                    sample_q <= to_sample(data_q);
                    valid_q  <= 1'b1;
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    cs_n_q  <= 1'b1;
                    sclk_q  <= 1'b0;
                end
            endcase
        end
    end

    assign adc_cs_n     = cs_n_q;
    assign adc_sclk     = sclk_q;
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Bench for adc_spi_sampler: ADC frame model, vector table plus random frames, timing and corner sequences.
module tb_adc_spi_sampler;
    localparam int W    = 10;
    localparam int FB   = 16;
    localparam int NB   = 3;
    localparam int SDIV = 200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst = 1'b1;
    logic                enable = 1'b0;
    logic                adc_miso = 1'b0;
    logic                adc_cs_n, adc_sclk, sample_valid, overrun;
    logic signed [W-1:0] sample_out;

    logic                rst_d = 1'b1;
    logic                en_d = 1'b0;
    logic                miso_d = 1'b0;
    logic                cs_d, sclk_d, valid_d, ovr_d;
    logic signed [W-1:0] sample_d;

    adc_spi_sampler #(.SAMPLE_DIV(SDIV)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_miso(adc_miso),
        .sample_out(sample_out), .sample_valid(sample_valid), .overrun(overrun)
    );

    adc_spi_sampler dut_def (
        .clk(clk), .rst(rst_d), .enable(en_d),
        .adc_cs_n(cs_d), .adc_sclk(sclk_d), .adc_miso(miso_d),
        .sample_out(sample_d), .sample_valid(valid_d), .overrun(ovr_d)
    );

    int total = 0;
    int bad = 0;

    int cyc = 0;
    int cs_low_total = 0;
    int rise_total = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (!adc_cs_n) cs_low_total <= cs_low_total + 1;
    always @(posedge adc_sclk) rise_total <= rise_total + 1;

    // ADC model: loads a frame when CS falls, moves to the next bit on each SCLK fall.
    logic [FB-1:0] next_frame = '0;
    logic [FB-1:0] cur_frame = '0;
    int            bit_idx = 0;
    logic          prev_cs = 1'b1;
    logic          prev_sclk = 1'b0;
    always @(adc_cs_n or adc_sclk) begin
        if (adc_cs_n) begin
            bit_idx = 0;
        end else if (prev_cs) begin
            cur_frame = next_frame;
            bit_idx   = 0;
        end else if (prev_sclk && !adc_sclk) begin
            bit_idx = bit_idx + 1;
        end
        prev_cs   = adc_cs_n;
        prev_sclk = adc_sclk;
        adc_miso  = (bit_idx < FB) ? cur_frame[FB-1-bit_idx] : 1'b0;
    end

    function automatic int model_sample(input logic [FB-1:0] frame);
        int raw;
        raw = (int'(frame) >> (FB - NB - W)) % (1 << W);
`ifdef ADC_SPI_TWOS_COMP_EN
        return raw - (1 << (W - 1));
`else
        return (raw >= (1 << (W - 1))) ? raw - (1 << W) : raw;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget && n < 0; i++) begin
            step();
            if (sample_valid) n = i;
        end
    endtask

    task automatic wait_cs_low(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget && n < 0; i++) begin
            step();
            if (!adc_cs_n) n = i;
        end
    endtask

    typedef struct {
        logic [FB-1:0] frame;
        int            exp_twos;
        int            exp_raw;
    } vec_t;

    vec_t          vecs[6];
    logic [FB-1:0] frames[12];
    int            exps[12];

    initial begin
        int n, n_cs, n_v, last_v, b_cs, b_rise, seen;
        logic [FB-1:0] fr;

        vecs[0] = '{{3'b101, 10'h3FF, 3'b000},  511,   -1};
        vecs[1] = '{{3'b000, 10'h200, 3'b000},    0, -512};
        vecs[2] = '{{3'b111, 10'h000, 3'b111}, -512,    0};
        vecs[3] = '{{3'b010, 10'h155, 3'b101}, -171,  341};
        vecs[4] = '{{3'b001, 10'h2AA, 3'b010},  170, -342};
        vecs[5] = '{{3'b110, 10'h1FF, 3'b011},   -1,  511};
        for (int i = 0; i < 12; i++) begin
            if (i < 6) begin
                frames[i] = vecs[i].frame;
`ifdef ADC_SPI_TWOS_COMP_EN
                exps[i] = vecs[i].exp_twos;
`else
                exps[i] = vecs[i].exp_raw;
`endif
            end else begin
                frames[i] = FB'($urandom);
                exps[i]   = model_sample(frames[i]);
            end
        end

        // Default-parameter instance: reset values and first-frame timing after release.
        en_d = 1'b1;
        repeat (5) step();
        chk("def_rst_cs_n", int'(cs_d), 1);
        chk("def_rst_sclk", int'(sclk_d), 0);
        chk("def_rst_sample", int'(sample_d), 0);
        chk("def_rst_valid", int'(valid_d), 0);
        chk("def_rst_overrun", int'(ovr_d), 0);
        chk("main_rst_cs_n", int'(adc_cs_n), 1);
        rst_d = 1'b0;
        n_cs = -1;
        n_v  = -1;
        for (int i = 1; i <= 20300 && n_v < 0; i++) begin
            step();
            if (n_cs < 0 && !cs_d) n_cs = i;
            if (valid_d) n_v = i;
        end
        chk("def_first_cs_fall", n_cs, 20001);
        chk("def_first_valid", n_v, 20138);
        chk("def_sample_zero_frame", int'(sample_d), model_sample('0));
        rst_d = 1'b1;

        // Main instance: vector table then random frames, steady-state timing per frame.
        next_frame = frames[0];
        b_cs   = cs_low_total;
        b_rise = rise_total;
        last_v = 0;
        enable = 1'b1;
        rst    = 1'b0;
        for (int i = 0; i < 12; i++) begin
            wait_valid(SDIV + 200, n);
            chk("strobe_seen", int'(n >= 0), 1);
            if (i == 0) chk("first_valid_main", n, SDIV + 138);
            else chk("valid_spacing", cyc - last_v, SDIV);
            chk(i < 6 ? "vector_sample" : "random_sample", int'(sample_out), exps[i]);
            chk("sclk_rises", rise_total - b_rise, 16);
            chk("cs_low_cycles", cs_low_total - b_cs, 136);
            last_v = cyc;
            b_cs   = cs_low_total;
            b_rise = rise_total;
            if (i < 11) next_frame = frames[i + 1];
            step();
            chk("strobe_width", int'(sample_valid), 0);
        end
        chk("no_overrun_steady", int'(overrun), 0);

        // Extra tick forced into the SHIFT state.
        fr = FB'($urandom);
        next_frame = fr;
        wait_cs_low(SDIV, n);
        chk("ovr_cs_fall_seen", int'(n >= 0), 1);
        repeat (30) step();
        force dut.tick_q = 1'b1;
        step();
        chk("overrun_set", int'(overrun), 1);
        release dut.tick_q;
        wait_valid(SDIV, n);
        chk("ovr_strobe_time", n, 106);
        chk("ovr_sample", int'(sample_out), model_sample(fr));
        fr = FB'($urandom);
        next_frame = fr;
        wait_cs_low(SDIV, n);
        chk("ovr_next_cs_fall", n, 63);
        chk("overrun_sticky", int'(overrun), 1);

        // Reset asserted during SHIFT bit 7.
        repeat (60) step();
        chk("bit7_sclk_high", int'(adc_sclk), 1);
        rst = 1'b1;
        #1;
        chk("midrst_cs_n", int'(adc_cs_n), 1);
        chk("midrst_sclk", int'(adc_sclk), 0);
        chk("midrst_valid", int'(sample_valid), 0);
        chk("midrst_sample", int'(sample_out), 0);
        chk("midrst_overrun", int'(overrun), 0);
        repeat (3) step();
        rst = 1'b0;
        wait_valid(150, n);
        chk("no_strobe_after_rst", n, -1);
        chk("sample_after_rst", int'(sample_out), 0);

        // Enable dropped during SETUP.
        fr = FB'($urandom);
        next_frame = fr;
        wait_cs_low(100, n);
        chk("en_cs_fall_seen", int'(n >= 0), 1);
        step();
        enable = 1'b0;
        wait_valid(SDIV, n);
        chk("en_drop_strobe_time", n, 136);
        chk("en_drop_sample", int'(sample_out), model_sample(fr));
        b_cs   = cs_low_total;
        b_rise = rise_total;
        seen   = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (sample_valid) seen = seen + 1;
        end
        chk("en_low_strobes", seen, 0);
        chk("en_low_sclk_rises", rise_total - b_rise, 0);
        chk("en_low_cs_cycles", cs_low_total - b_cs, 0);
        fr = FB'($urandom);
        next_frame = fr;
        enable = 1'b1;
        wait_cs_low(SDIV + 100, n);
        chk("en_restart_cs_fall", n, SDIV + 1);
        wait_valid(SDIV, n);
        chk("en_restart_strobe_time", n, 137);
        chk("en_restart_sample", int'(sample_out), model_sample(fr));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
